// File: rtl/rx_frame_timing_counter_if.sv
// Handshake between the RX FSM and the frame timing engine: config and
// enable flow toward the counter, while timing strobes and the field code flow back.
interface rx_frame_timing_counter_if #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
);
    logic                  enable;
    logic [PRESCALE_W-1:0] prescale;
    logic [3:0]            data_len;
    logic                  PAR_EN;
    logic                  stop2;

    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  sample_stb;
    logic [1:0]            sample_idx;
    logic                  bit_done;
    logic                  frame_done;
    logic [2:0]            field;
    logic                  busy;
    logic                  cfg_err;

    modport master (
        output enable, prescale, data_len, PAR_EN, stop2,
        input  bit_cnt, edge_cnt, sample_stb, sample_idx, bit_done,
               frame_done, field, busy, cfg_err
    );

    modport slave (
        input  enable, prescale, data_len, PAR_EN, stop2,
        output bit_cnt, edge_cnt, sample_stb, sample_idx, bit_done,
               frame_done, field, busy, cfg_err
    );
endinterface

// File: rtl/rx_frame_timing_counter.sv
// Oversampling timing engine for the UART receiver: counts edges per bit and
// bits per frame, and emits mid-bit sample strobes, boundary pulses and the field code.
module rx_frame_timing_counter #(
    parameter int PRESCALE_W    = 6,
    parameter int MAX_DATA_BITS = 9,
    parameter int BIT_CNT_W     = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    rx_frame_timing_counter_if.slave tim
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    typedef enum logic [2:0] {
        FIELD_START  = 3'd0,
        FIELD_DATA   = 3'd1,
        FIELD_PARITY = 3'd2,
        FIELD_STOP1  = 3'd3,
        FIELD_STOP2  = 3'd4
    } field_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [3:0]            len_q, len_d;
    logic                  pe_q, pe_d;
    logic                  s2_q, s2_d;
    logic                  bit_done_q, bit_done_d;
    logic                  frame_done_q, frame_done_d;
    logic                  cfg_err_q, cfg_err_d;

    logic                  clamp_p, clamp_len;
    logic [PRESCALE_W-1:0] p_in;
    logic [3:0]            len_in;
    logic [PRESCALE_W-1:0] p_eff, p_last, half_p;
    logic [3:0]            len_eff;
    logic                  pe_eff, s2_eff;
    logic [BIT_CNT_W-1:0]  n_last;
    logic                  edge_wrap, last_bit;
    logic                  stb_c;
    logic [1:0]            idx_c;
    field_e                field_c;
    logic [BIT_CNT_W-1:0]  len_b, par_idx, stop1_idx;

    // Sanitised config as it would be latched this cycle.
    always_comb begin
        clamp_p   = tim.prescale < PRESCALE_W'(4);
        clamp_len = (tim.data_len < 4'd5) || (int'(tim.data_len) > MAX_DATA_BITS);
        p_in      = clamp_p   ? PRESCALE_W'(4) : tim.prescale;
        len_in    = clamp_len ? 4'd8           : tim.data_len;
    end

    // The latch cycle already counts edge 0, so it must see the incoming config.
    always_comb begin
        p_eff   = (state_q == ST_IDLE) ? p_in       : p_q;
        len_eff = (state_q == ST_IDLE) ? len_in     : len_q;
        pe_eff  = (state_q == ST_IDLE) ? tim.PAR_EN : pe_q;
        s2_eff  = (state_q == ST_IDLE) ? tim.stop2  : s2_q;
        p_last  = p_eff - PRESCALE_W'(1);
        n_last  = BIT_CNT_W'(len_eff) + BIT_CNT_W'(pe_eff) + BIT_CNT_W'(s2_eff)
                + BIT_CNT_W'(1);
        edge_wrap = (edge_q == p_last);
        last_bit  = (bit_q == n_last);
    end

    always_comb begin
        state_d      = state_q;
        edge_d       = edge_q;
        bit_d        = bit_q;
        p_d          = p_q;
        len_d        = len_q;
        pe_d         = pe_q;
        s2_d         = s2_q;
        bit_done_d   = 1'b0;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;

        if (!tim.enable) begin
            state_d = ST_IDLE;
            edge_d  = '0;
            bit_d   = '0;
        end else begin
            if (state_q == ST_IDLE) begin
                p_d       = p_in;
                len_d     = len_in;
                pe_d      = tim.PAR_EN;
                s2_d      = tim.stop2;
                cfg_err_d = clamp_p | clamp_len;
                state_d   = ST_RUN;
            end
            if (edge_wrap) begin
                edge_d     = '0;
                bit_done_d = 1'b1;
                if (last_bit) begin
                    bit_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    bit_d = bit_q + BIT_CNT_W'(1);
                end
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            edge_q       <= '0;
            bit_q        <= '0;
            p_q          <= PRESCALE_W'(4);
            len_q        <= 4'd8;
            pe_q         <= 1'b0;
            s2_q         <= 1'b0;
            bit_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_q       <= edge_d;
            bit_q        <= bit_d;
            p_q          <= p_d;
            len_q        <= len_d;
            pe_q         <= pe_d;
            s2_q         <= s2_d;
            bit_done_q   <= bit_done_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Three samples centred on the middle edge; P >= 4 keeps half_p-2 non-negative.
    always_comb begin
        half_p = p_eff >> 1;
        stb_c  = 1'b0;
        idx_c  = 2'd0;
        if (tim.enable && (edge_q >= half_p - PRESCALE_W'(2)) && (edge_q <= half_p)) begin
            stb_c = 1'b1;
            idx_c = 2'(edge_q - (half_p - PRESCALE_W'(2)));
        end
    end

    always_comb begin
        len_b     = BIT_CNT_W'(len_q);
        par_idx   = len_b + BIT_CNT_W'(1);
        stop1_idx = len_b + BIT_CNT_W'(pe_q) + BIT_CNT_W'(1);
        field_c   = FIELD_START;
        if (bit_q == '0) begin
            field_c = FIELD_START;
        end else if (bit_q <= len_b) begin
            field_c = FIELD_DATA;
        end else if (pe_q && (bit_q == par_idx)) begin
            field_c = FIELD_PARITY;
        end else if (bit_q == stop1_idx) begin
            field_c = FIELD_STOP1;
        end else if (s2_q && (bit_q == stop1_idx + BIT_CNT_W'(1))) begin
            field_c = FIELD_STOP2;
        end
    end

    assign tim.bit_cnt    = bit_q;
    assign tim.edge_cnt   = edge_q;
    assign tim.sample_stb = stb_c;
    assign tim.sample_idx = idx_c;
    assign tim.bit_done   = bit_done_q;
    assign tim.frame_done = frame_done_q;
    assign tim.field      = field_c;
    assign tim.busy       = (state_q == ST_RUN);
    assign tim.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_rx_frame_timing_counter.sv
// Scenario bench for the RX frame timing engine: a position-based reference
// model queues the expected outputs of each cycle, and they are popped when the DUT is sampled.
module tb_rx_frame_timing_counter;
    localparam int PW  = 6;
    localparam int MDB = 9;
    localparam int BW  = 4;

    typedef struct packed {
        logic [BW-1:0] bit_cnt;
        logic [PW-1:0] edge_cnt;
        logic          stb;
        logic [1:0]    idx;
        logic          bd;
        logic          fd;
        logic [2:0]    field;
        logic          busy;
        logic          ce;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_frame_timing_counter_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

    rx_frame_timing_counter #(
        .PRESCALE_W(PW), .MAX_DATA_BITS(MDB), .BIT_CNT_W(BW)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .tim(bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    obs_t exp_q[$];

    // Reference state: position k counts edges since the start of the frame.
    int m_k = 0, m_p = 4, m_l = 8;
    bit m_pe = 0, m_s2 = 0, m_busy = 0, m_bd = 0, m_fd = 0, m_ce = 0;

    function automatic int clamp_p(int x);
        return (x < 4) ? 4 : x;
    endfunction

    function automatic int clamp_l(int x);
        return (x < 5 || x > MDB) ? 8 : x;
    endfunction

    function automatic obs_t expect_now();
        obs_t o;
        int p, e, b, m, stop1;
        p = m_busy ? m_p : clamp_p(int'(bus.prescale));
        e = m_k % m_p;
        b = m_k / m_p;
        m = p / 2;
        o = '0;
        o.bit_cnt  = BW'(b);
        o.edge_cnt = PW'(e);
        if (bus.enable && e >= m - 2 && e <= m) begin
            o.stb = 1'b1;
            o.idx = 2'(e - (m - 2));
        end
        stop1 = m_l + 1 + int'(m_pe);
        if (b == 0)                       o.field = 3'd0;
        else if (b <= m_l)                o.field = 3'd1;
        else if (m_pe && b == m_l + 1)    o.field = 3'd2;
        else if (b == stop1)              o.field = 3'd3;
        else if (m_s2 && b == stop1 + 1)  o.field = 3'd4;
        o.bd   = m_bd;
        o.fd   = m_fd;
        o.busy = m_busy;
        o.ce   = m_ce;
        return o;
    endfunction

    task automatic model_edge();
        int n;
        if (!rst_n) begin
            m_k = 0; m_p = 4; m_l = 8; m_pe = 0; m_s2 = 0;
            m_busy = 0; m_bd = 0; m_fd = 0; m_ce = 0;
        end else if (!bus.enable) begin
            m_k = 0; m_busy = 0; m_bd = 0; m_fd = 0; m_ce = 0;
        end else begin
            m_ce = 0;
            if (!m_busy) begin
                m_p  = clamp_p(int'(bus.prescale));
                m_l  = clamp_l(int'(bus.data_len));
                m_pe = bus.PAR_EN;
                m_s2 = bus.stop2;
                m_ce = (int'(bus.prescale) < 4) || (int'(bus.data_len) < 5)
                    || (int'(bus.data_len) > MDB);
            end
            n      = 2 + m_l + int'(m_pe) + int'(m_s2);
            m_bd   = ((m_k + 1) % m_p) == 0;
            m_fd   = (m_k == n * m_p - 1);
            m_k    = m_fd ? 0 : m_k + 1;
            m_busy = !m_fd;
        end
    endtask

    function automatic obs_t snap();
        obs_t o;
        o.bit_cnt  = bus.bit_cnt;
        o.edge_cnt = bus.edge_cnt;
        o.stb      = bus.sample_stb;
        o.idx      = bus.sample_idx;
        o.bd       = bus.bit_done;
        o.fd       = bus.frame_done;
        o.field    = bus.field;
        o.busy     = bus.busy;
        o.ce       = bus.cfg_err;
        return o;
    endfunction

    task automatic observe();
        exp_q.push_back(expect_now());
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_cfg(int p, int l, bit pe, bit s2);
        bus.prescale = PW'(p);
        bus.data_len = 4'(l);
        bus.PAR_EN   = pe;
        bus.stop2    = s2;
    endtask

    task automatic test_reset();
        obs_t got, e;
        rst_n = 1'b0;
        bus.enable = 1'b0;
        set_cfg(8, 8, 0, 0);
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            if (i == 1) rst_n = 1'b1;
            observe();
            got = snap();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_model cyc%0d got=%h exp=%h", i, got, e);
            end
            vectors++;
            if (got !== obs_t'(0)) begin
                miscompares++;
                $display("FAIL reset_zero cyc%0d got=%h exp=0", i, got);
            end
            $display("reset cyc%0d out=%h", i, got);
            tick();
        end
    endtask

    task automatic test_basic();
        obs_t got, e;
        int bd_n = 0, stb_n = 0, stb_bad = 0, fd_at = 0;
        set_cfg(8, 8, 0, 0);
        for (int i = 1; i <= 81; i++) begin
            bus.enable = (i <= 80);
            observe();
            got = snap();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL basic cyc%0d got=%h exp=%h", i, got, e);
            end
            if (got.bd) bd_n++;
            if (got.fd) fd_at = i;
            if (got.stb) begin
                stb_n++;
                if (got.edge_cnt < 2 || got.edge_cnt > 4 || int'(got.idx) != int'(got.edge_cnt) - 2)
                    stb_bad++;
            end
            tick();
        end
        vectors++;
        if (bd_n !== 10) begin miscompares++; $display("FAIL basic_bit_done_count got=%0d exp=10", bd_n); end
        vectors++;
        if (fd_at !== 81) begin miscompares++; $display("FAIL basic_frame_done_cycle got=%0d exp=81", fd_at); end
        vectors++;
        if (stb_n !== 30 || stb_bad !== 0) begin
            miscompares++;
            $display("FAIL basic_strobes got=%0d bad=%0d exp=30 bad=0", stb_n, stb_bad);
        end
        $display("basic frame: bit_done=%0d frame_done@%0d strobes=%0d", bd_n, fd_at, stb_n);
    endtask

    task automatic test_field_seq();
        obs_t got, e;
        int fd_at = 0;
        int f[11];
        int exp_f[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 2, 3, 4};
        set_cfg(16, 7, 1, 1);
        for (int i = 1; i <= 177; i++) begin
            bus.enable = (i <= 176);
            observe();
            got = snap();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL field cyc%0d got=%h exp=%h", i, got, e);
            end
            if (i <= 176 && (i - 1) % 16 == 0) f[(i - 1) / 16] = int'(got.field);
            if (got.fd) fd_at = i;
            tick();
        end
        for (int b = 0; b < 11; b++) begin
            vectors++;
            if (f[b] !== exp_f[b]) begin
                miscompares++;
                $display("FAIL field_bit%0d got=%0d exp=%0d", b, f[b], exp_f[b]);
            end
        end
        vectors++;
        if (fd_at !== 177) begin miscompares++; $display("FAIL field_frame_done_cycle got=%0d exp=177", fd_at); end
        $display("field frame: frame_done@%0d", fd_at);
    endtask

    task automatic test_abort();
        obs_t got, e;
        int fd_n = 0, fd_at = 0;
        set_cfg(10, 8, 0, 0);
        for (int i = 1; i <= 89; i++) begin
            if (i == 46) set_cfg(6, 5, 0, 0);
            bus.enable = (i <= 45) || (i >= 47 && i <= 88);
            observe();
            got = snap();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL abort cyc%0d got=%h exp=%h", i, got, e);
            end
            if (i == 46) begin
                vectors++;
                if (got.bit_cnt !== 4'd4 || got.edge_cnt !== 6'd5 || got.stb !== 1'b0) begin
                    miscompares++;
                    $display("FAIL abort_drop_point got=%h exp bit=4 edge=5 stb=0", got);
                end
            end
            if (i == 47) begin
                vectors++;
                if (got !== obs_t'(0)) begin
                    miscompares++;
                    $display("FAIL abort_cleared got=%h exp=0", got);
                end
            end
            if (got.fd) begin fd_n++; fd_at = i; end
            tick();
        end
        vectors++;
        if (fd_n !== 1 || fd_at !== 89) begin
            miscompares++;
            $display("FAIL abort_refresh_frame got=%0d@%0d exp=1@89", fd_n, fd_at);
        end
        $display("abort: frame_done count=%0d last@%0d", fd_n, fd_at);
    endtask

    task automatic test_clamp();
        obs_t got, e;
        int ce_n = 0, ce_at = 0, bd_n = 0, fd_at = 0;
        set_cfg(2, 12, 0, 0);
        for (int i = 1; i <= 41; i++) begin
            bus.enable = (i <= 40);
            observe();
            got = snap();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL clamp cyc%0d got=%h exp=%h", i, got, e);
            end
            if (got.ce) begin ce_n++; ce_at = i; end
            if (got.bd) bd_n++;
            if (got.fd) fd_at = i;
            tick();
        end
        vectors++;
        if (ce_n !== 1 || ce_at !== 2) begin
            miscompares++;
            $display("FAIL clamp_cfg_err got=%0d@%0d exp=1@2", ce_n, ce_at);
        end
        vectors++;
        if (bd_n !== 10 || fd_at !== 41) begin
            miscompares++;
            $display("FAIL clamp_frame got bd=%0d fd@%0d exp bd=10 fd@41", bd_n, fd_at);
        end
        $display("clamp: cfg_err=%0d@%0d frame_done@%0d", ce_n, ce_at, fd_at);
    endtask

    task automatic test_back_to_back();
        obs_t got, e;
        int bd_n = 0, bd_last = 0, fd_at = 0;
        set_cfg(8, 8, 0, 0);
        for (int i = 1; i <= 121; i++) begin
            if (i == 10) bus.prescale = PW'(32);
            bus.enable = (i <= 120);
            observe();
            got = snap();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL b2b cyc%0d got=%h exp=%h", i, got, e);
            end
            if (got.bd) begin bd_n++; bd_last = i; end
            if (got.fd) fd_at = i;
            if (i == 82) begin
                vectors++;
                if (got.edge_cnt !== 6'd1 || got.busy !== 1'b1 || got.bit_cnt !== 4'd0) begin
                    miscompares++;
                    $display("FAIL b2b_no_gap got=%h exp edge=1 busy=1 bit=0", got);
                end
            end
            tick();
        end
        vectors++;
        if (fd_at !== 81) begin miscompares++; $display("FAIL b2b_frame_done got=%0d exp=81", fd_at); end
        vectors++;
        if (bd_n !== 11 || bd_last !== 113) begin
            miscompares++;
            $display("FAIL b2b_bit_done got=%0d last@%0d exp=11 last@113", bd_n, bd_last);
        end
        $display("back_to_back: frame_done@%0d bit_done=%0d last@%0d", fd_at, bd_n, bd_last);
    endtask

    task automatic test_reset_midframe();
        obs_t got, e;
        set_cfg(8, 8, 0, 0);
        for (int i = 1; i <= 52; i++) begin
            rst_n = (i != 49);
            bus.enable = (i <= 49);
            observe();
            got = snap();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL rst_mid cyc%0d got=%h exp=%h", i, got, e);
            end
            if (i == 49) begin
                vectors++;
                if (got.bit_cnt !== 4'd6 || got.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rst_mid_point got=%h exp bit=6 busy=1", got);
                end
            end
            if (i == 50) begin
                vectors++;
                if (got !== obs_t'(0)) begin
                    miscompares++;
                    $display("FAIL rst_mid_cleared got=%h exp=0", got);
                end
            end
            if (i == 45) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            tick();
        end
        rst_n = 1'b1;
        $display("reset_midframe: done");
    endtask

    initial begin
        bus.enable = 1'b0;
        set_cfg(8, 8, 0, 0);
        test_reset();
        test_basic();
        test_field_seq();
        test_abort();
        test_clamp();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
